// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: packs a length-prefixed, checksummed image into 32-bit words,
// writes them to instruction memory and releases the core once the checksum has passed.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam int unsigned MaxWords = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            sum_q, sum_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           shift_q, shift_d;
  logic [15:0]           words_q, words_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  accept;
  logic [7:0]            sum_next;
  logic [15:0]           len_full;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StLenHi;
      len_q      <= '0;
      sum_q      <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign accept   = in_valid & in_ready;
  assign sum_next = sum_q + in_data;
  assign len_full = {len_q[15:8], in_data};

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sum_d      = sum_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (accept) begin
      sum_d = sum_next;
      unique case (state_q)
        StLenHi: begin
          len_d   = {in_data, 8'h00};
          state_d = StLenLo;
        end
        StLenLo: begin
          len_d = len_full;
          if (32'(len_full) > MaxWords) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StChk;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {shift_q[15:0], in_data};
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_q[ADDR_WIDTH-1:0];
            wdata_d = {shift_q, in_data};
            words_d = words_q + 16'd1;
            if (words_q == len_q - 16'd1) begin
              state_d = StChk;
            end
          end
        end
        StChk: begin
          state_d = (sum_next == 8'd0) ? StDone : StErr;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready     = !reset && (state_q inside {StLenHi, StLenLo, StData, StChk});
    mem_we       = we_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    done         = (state_q == StDone);
    error        = (state_q == StErr);
    cpu_reset    = (state_q != StDone);
    words_loaded = words_q;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle MIPS core.
- Accepts a byte stream over a valid/ready handshake and packs the bytes into 32-bit instruction words.
- Writes each word into the word-addressed instruction memory (PC increments by 1 per instruction).
- Holds the core in reset until the whole image has been written and its checksum has passed.

Parameters:
- ADDR_WIDTH, 8, instruction-memory address width in words; MAX_WORDS = 2**ADDR_WIDTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one-cycle pulse per word.
- mem_addr  out  ADDR_WIDTH  word address of the write.
- mem_wdata  out  32  instruction word to write.
- cpu_reset  out  1  reset to the MIPS core; high until the load succeeds.
- done  out  1  image loaded and checksum OK; sticky until reset.
- error  out  1  length overflow or checksum mismatch; sticky until reset.
- words_loaded  out  16  count of words written so far.

Behaviour:
- Handshake:
  - A byte is accepted only on an edge where in_valid=1 and in_ready=1.
  - in_data is ignored otherwise; gaps in in_valid are legal at any point.
- Stream format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - 4*N data bytes.
  - One checksum byte CHK.
- Checksum rule: the 8-bit sum of all bytes (length bytes, data bytes, CHK) mod 256 must equal 0.
- Word packing:
  - Big-endian: first byte of a word goes to [31:24], fourth byte to [7:0].
  - Bytes are assembled in a shift register.
- States: S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR.
- in_ready = 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CHK; 0 in S_DONE, S_ERR and any cycle where reset=1.
- Transitions, each on an accepted byte:
  - S_LEN_HI -> S_LEN_LO.
  - S_LEN_LO:
    - N > MAX_WORDS -> S_ERR, with no memory writes.
    - N = 0 -> S_CHK.
    - Otherwise -> S_DATA.
  - S_DATA, on the 4th byte of word i:
    - mem_we=1 in the following cycle only, with mem_addr=i[ADDR_WIDTH-1:0] and mem_wdata=the packed word.
    - words_loaded increments on that same edge.
    - If i = N-1, go to S_CHK; otherwise stay in S_DATA.
  - S_CHK:
    - Running sum + CHK = 0 mod 256 -> S_DONE.
    - Otherwise -> S_ERR.
  - S_DONE and S_ERR are terminal until reset.
- Output timing:
  - done=1 and cpu_reset=0 from the edge that accepts a valid CHK onward (registered).
  - error=1 from the edge entering S_ERR.
  - cpu_reset stays 1 in S_ERR.
- Back-to-back operation:
  - A byte may be accepted in the same cycle mem_we is high; no bubble is required between words.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
- Reset:
  - Outputs during/after reset: in_ready=0 while reset high, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0.
  - Internal state after reset: state=S_LEN_HI, checksum=0, byte index=0.
  - Reset mid-load aborts immediately; partial words are discarded.
  - Already-written memory contents are not cleared; a fresh image overwrites them.
- done and error are never high together.
- N = MAX_WORDS is legal; the last address is MAX_WORDS-1.

Test Plan:
- Two-word image, correct checksum: stream 00 02 20 01 00 05 00 00 00 00 D8 -> mem_we pulses with (addr 0, 0x20010005) then (addr 1, 0x00000000); words_loaded=2; done=1; cpu_reset=0; in_ready=0 afterwards.
- Same image, last byte 00 instead of D8 -> both writes occur; error=1; done=0; cpu_reset stays 1; in_ready=0.
- Empty image: 00 00 00 -> no mem_we; done=1 on the edge accepting the 3rd byte; cpu_reset=0 in the next cycle.
- Overflow, ADDR_WIDTH=8: length 01 01 (257) -> error=1 after the 2nd byte; no mem_we ever; further in_valid ignored.
- Throttled stream: rerun the two-word image with in_valid randomly low ~50% of cycles -> identical writes, addresses, data and done; byte count unaffected by idle cycles.
- Reset during S_DATA after 6 data bytes: pulse reset for 1 cycle -> words_loaded=0, cpu_reset=1, no stray mem_we; reloading the full two-word image then ends with done=1.
